// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin arbiter sharing an 8-digit 74HC595 hex display
// between four requesters, with a minimum hold time per owner and a lock input.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous reset, active-high
//   req[3:0]     level request per requester, held until the matching ack
//   val0..val3   32-bit value offered by each requester (stable while req high)
//   lock         1 = freeze the hold countdown and block ownership changes
//   ack[3:0]     one-cycle pulse, the value of that requester was captured
//   data0..data3 registered display bytes, data3 = val[31:24] ... data0 = val[7:0]
//   owner        index of the current owner
//   active       1 once any requester has been granted since reset
//   expired      1 = hold time of the current owner has elapsed
module seg_disp_arbiter #(
   parameter int unsigned HOLD_CYCLES = 50000000,
   parameter int unsigned HOLD_W      = 26
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [3:0]  req,
   input  logic [31:0] val0,
   input  logic [31:0] val1,
   input  logic [31:0] val2,
   input  logic [31:0] val3,
   input  logic        lock,
   output logic [3:0]  ack,
   output logic [7:0]  data0,
   output logic [7:0]  data1,
   output logic [7:0]  data2,
   output logic [7:0]  data3,
   output logic [1:0]  owner,
   output logic        active,
   output logic        expired
);

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   // The state is fully encoded by the active/expired flags.
   typedef enum logic [1:0] {StIdle, StHold, StExpired} state_e;

   state_e            state;
   logic [3:0]        ack_q, ack_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        rr_q, rr_d;
   logic              active_q, active_d;
   logic              expired_q, expired_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;

   logic [1:0]        win, cand, sel;
   logic              found, grant, update;
   logic [31:0]       sel_val;

   always_comb begin
      if (!active_q) begin
         state = StIdle;
      end else if (expired_q) begin
         state = StExpired;
      end else begin
         state = StHold;
      end
   end

   // Search order rr+1, rr+2, rr+3, rr: the last owner comes last.
   always_comb begin
      found = 1'b0;
      win   = rr_q;
      cand  = rr_q;
      for (int i = 1; i <= 4; i++) begin
         cand = rr_q + 2'(i);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      case (sel)
         2'd0:    sel_val = val0;
         2'd1:    sel_val = val1;
         2'd2:    sel_val = val2;
         default: sel_val = val3;
      endcase
   end

   always_comb begin
      ack_d     = 4'b0000;
      data_d    = data_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      active_d  = active_q;
      expired_d = expired_q;
      cnt_d     = cnt_q;
      grant     = 1'b0;
      update    = 1'b0;
      sel       = owner_q;

      case (state)
         StIdle: begin
            grant = |req;
         end
         StHold: begin
            if (!lock && cnt_q != '0) begin
               cnt_d     = cnt_q - HOLD_W'(1);
               expired_d = (cnt_q == HOLD_W'(1));
            end
            update = req[owner_q];
         end
         StExpired: begin
            // A lone owner request is re-granted through the round-robin path.
            if (!lock && |req) begin
               grant = 1'b1;
            end else begin
               update = req[owner_q];
            end
         end
         default: ;
      endcase

      if (grant) begin
         sel       = win;
         owner_d   = win;
         rr_d      = win;
         active_d  = 1'b1;
         cnt_d     = HOLD_LOAD;
         expired_d = (HOLD_LOAD == '0);
      end

      if (grant || update) begin
         data_d = sel_val;
         ack_d  = 4'b0001 << sel;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ack_q     <= 4'b0000;
         data_q    <= 32'h0;
         owner_q   <= 2'd0;
         rr_q      <= 2'd3;
         active_q  <= 1'b0;
         expired_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         ack_q     <= ack_d;
         data_q    <= data_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         active_q  <= active_d;
         expired_q <= expired_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ack     = ack_q;
   assign data0   = data_q[7:0];
   assign data1   = data_q[15:8];
   assign data2   = data_q[23:16];
   assign data3   = data_q[31:24];
   assign owner   = owner_q;
   assign active  = active_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Testbench for seg_disp_arbiter (HOLD_CYCLES=4): vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_seg_disp_arbiter;

   localparam int unsigned HOLD = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic [3:0]  req     = 4'b0000;
   logic        lock    = 1'b0;
   logic [31:0] vals [4];
   logic [3:0]  ack;
   logic [7:0]  data0, data1, data2, data3;
   logic [1:0]  owner;
   logic        active, expired;

   int total = 0;
   int bad   = 0;

   seg_disp_arbiter #(
      .HOLD_CYCLES(HOLD),
      .HOLD_W     (4)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .req    (req),
      .val0   (vals[0]),
      .val1   (vals[1]),
      .val2   (vals[2]),
      .val3   (vals[3]),
      .lock   (lock),
      .ack    (ack),
      .data0  (data0),
      .data1  (data1),
      .data2  (data2),
      .data3  (data3),
      .owner  (owner),
      .active (active),
      .expired(expired)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: ownership plus a count of unlocked edges since the grant.
   logic [3:0]  m_ack;
   logic [31:0] m_data;
   int          m_owner, m_rr, m_elapsed;
   logic        m_active, m_expired;

   task automatic model_step(input logic rst_in, input logic [3:0] r, input logic lk);
      int c;
      logic granted;
      granted = 1'b0;
      m_ack   = 4'b0000;
      if (rst_in) begin
         m_data = 0; m_owner = 0; m_rr = 3; m_elapsed = 0;
         m_active = 1'b0; m_expired = 1'b0;
         return;
      end
      if ((!m_active || (m_expired && !lk)) && r != 4'b0000) begin
         for (int k = 1; k <= 4; k++) begin
            c = (m_rr + k) % 4;
            if (!granted && r[c]) begin
               granted   = 1'b1;
               m_owner   = c;
               m_rr      = c;
               m_data    = vals[c];
               m_ack[c]  = 1'b1;
               m_active  = 1'b1;
               m_elapsed = 0;
            end
         end
      end else if (m_active && r[m_owner]) begin
         m_data         = vals[m_owner];
         m_ack[m_owner] = 1'b1;
      end
      if (m_active && !granted && !lk && m_elapsed < 1000) m_elapsed++;
      m_expired = m_active && (m_elapsed >= HOLD - 1);
   endtask

   task automatic step(input logic rst_in, input logic [3:0] r, input logic lk);
      sys_rst = rst_in;
      req     = r;
      lock    = lk;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] e_ack, input logic [31:0] e_data,
                        input logic [1:0] e_owner, input logic e_act, input logic e_exp);
      logic [31:0] d;
      d = {data3, data2, data1, data0};
      total++;
      if (ack !== e_ack || d !== e_data || owner !== e_owner || active !== e_act ||
          expired !== e_exp) begin
         bad++;
         $display("FAIL %s: got ack=%b data=%h owner=%0d active=%b expired=%b, want ack=%b data=%h owner=%0d active=%b expired=%b",
                  name, ack, d, owner, active, expired, e_ack, e_data, e_owner, e_act, e_exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  r;
      logic        lk;
      logic [31:0] v0, v2, v3;
      logic [3:0]  e_ack;
      logic [31:0] e_data;
      logic [1:0]  e_owner;
      logic        e_act, e_exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [3:0] rr;
      logic       lk;

      for (int i = 0; i < 4; i++) vals[i] = 32'h0;

      // Reset, single grant, two contenders, reset of the rr pointer.
      tbl[0]  = '{1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'b0001, 1'b0, 32'h12345678, 32'h0, 32'h0,
                  4'b0001, 32'h12345678, 2'd0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 4'b0000, 1'b0, 32'h12345678, 32'h0, 32'h0,
                  4'b0000, 32'h12345678, 2'd0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 2'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 4'b0101, 1'b0, 32'hA0A0A0A0, 32'hC2C2C2C2, 32'h0,
                  4'b0001, 32'hA0A0A0A0, 2'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 4'b0100, 1'b0, 32'hA0A0A0A0, 32'hC2C2C2C2, 32'h0,
                  4'b0000, 32'hA0A0A0A0, 2'd0, 1'b1, 1'b0};
      tbl[6]  = tbl[5];
      tbl[7]  = '{1'b0, 4'b0100, 1'b0, 32'hA0A0A0A0, 32'hC2C2C2C2, 32'h0,
                  4'b0000, 32'hA0A0A0A0, 2'd0, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 4'b0100, 1'b0, 32'hA0A0A0A0, 32'hC2C2C2C2, 32'h0,
                  4'b0100, 32'hC2C2C2C2, 2'd2, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 32'hA0A0A0A0, 32'hC2C2C2C2, 32'h0,
                  4'b0000, 32'hC2C2C2C2, 2'd2, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 4'b1000, 1'b0, 32'hA0A0A0A0, 32'hC2C2C2C2, 32'h33333333,
                  4'b0000, 32'h0, 2'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 4'b1001, 1'b0, 32'h0F0F0F0F, 32'hC2C2C2C2, 32'h33333333,
                  4'b0001, 32'h0F0F0F0F, 2'd0, 1'b1, 1'b0};

      for (int i = 0; i < 12; i++) begin
         vals[0] = tbl[i].v0;
         vals[2] = tbl[i].v2;
         vals[3] = tbl[i].v3;
         step(tbl[i].rst, tbl[i].r, tbl[i].lk);
         check($sformatf("vec%0d", i), tbl[i].e_ack, tbl[i].e_data, tbl[i].e_owner,
               tbl[i].e_act, tbl[i].e_exp);
      end

      // Live update by the owner, pending requester granted on schedule.
      step(1'b1, 4'b0000, 1'b0);
      vals[1] = 32'h11111111; vals[3] = 32'h33333333;
      step(1'b0, 4'b0010, 1'b0);
      check("upd_grant", 4'b0010, 32'h11111111, 2'd1, 1'b1, 1'b0);
      step(1'b0, 4'b1000, 1'b0);
      check("upd_wait", 4'b0000, 32'h11111111, 2'd1, 1'b1, 1'b0);
      vals[1] = 32'hDEADBEEF;
      step(1'b0, 4'b1010, 1'b0);
      check("upd_live", 4'b0010, 32'hDEADBEEF, 2'd1, 1'b1, 1'b0);
      step(1'b0, 4'b1000, 1'b0);
      check("upd_exp", 4'b0000, 32'hDEADBEEF, 2'd1, 1'b1, 1'b1);
      step(1'b0, 4'b1000, 1'b0);
      check("upd_switch", 4'b1000, 32'h33333333, 2'd3, 1'b1, 1'b0);

      // Lock freezes the countdown and blocks the pending switch.
      step(1'b1, 4'b0000, 1'b0);
      vals[0] = 32'h00C0FFEE;
      step(1'b0, 4'b0001, 1'b0);
      check("lock_grant", 4'b0001, 32'h00C0FFEE, 2'd0, 1'b1, 1'b0);
      step(1'b0, 4'b1000, 1'b0);
      for (int e = 2; e <= 20; e++) begin
         step(1'b0, 4'b1000, 1'b1);
         check("lock_hold", 4'b0000, 32'h00C0FFEE, 2'd0, 1'b1, 1'b0);
      end
      step(1'b0, 4'b1000, 1'b0);
      check("lock_e21", 4'b0000, 32'h00C0FFEE, 2'd0, 1'b1, 1'b0);
      step(1'b0, 4'b1000, 1'b0);
      check("lock_e22", 4'b0000, 32'h00C0FFEE, 2'd0, 1'b1, 1'b1);
      step(1'b0, 4'b1000, 1'b0);
      check("lock_e23", 4'b1000, 32'h33333333, 2'd3, 1'b1, 1'b0);

      // Expired display persists with no requests, then a new grant reloads.
      step(1'b1, 4'b0000, 1'b0);
      vals[2] = 32'h2222AAAA;
      step(1'b0, 4'b0100, 1'b0);
      check("idle_grant", 4'b0100, 32'h2222AAAA, 2'd2, 1'b1, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      for (int e = 3; e < 103; e++) begin
         step(1'b0, 4'b0000, 1'b0);
         check("idle_persist", 4'b0000, 32'h2222AAAA, 2'd2, 1'b1, 1'b1);
      end
      vals[1] = 32'h1B1B1B1B;
      step(1'b0, 4'b0010, 1'b0);
      check("idle_regrant", 4'b0010, 32'h1B1B1B1B, 2'd1, 1'b1, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      check("reload_g2", 4'b0000, 32'h1B1B1B1B, 2'd1, 1'b1, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      check("reload_g3", 4'b0000, 32'h1B1B1B1B, 2'd1, 1'b1, 1'b1);

      // Randomized traffic: requesters drop after ack, sometimes abort early.
      rr = 4'b0000;
      lk = 1'b0;
      step(1'b1, rr, lk);
      model_step(1'b1, rr, lk);
      check("rand_rst", m_ack, m_data, 2'(m_owner), m_active, m_expired);
      for (int n = 0; n < 3000; n++) begin
         logic rs;
         for (int i = 0; i < 4; i++) begin
            if (rr[i] && (m_ack[i] || $urandom_range(0, 15) == 0)) begin
               rr[i] = 1'b0;
            end else if (!rr[i] && $urandom_range(0, 3) == 0) begin
               rr[i]   = 1'b1;
               vals[i] = $urandom;
            end
         end
         if ($urandom_range(0, 7) == 0) lk = ~lk;
         rs = ($urandom_range(0, 99) == 0);
         step(rs, rr, lk);
         model_step(rs, rr, lk);
         check("rand", m_ack, m_data, 2'(m_owner), m_active, m_expired);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
